// File: rtl/io_pkg.sv
// Shared definitions for the I/O slot bridge.
// Holds the bridge FSM state type, the interrupt-controller register offsets,
// the read data returned on errored accesses and bus-address field helpers.
package io_pkg;

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} io_state_e;

  // Register offsets inside the interrupt-controller slot.
  localparam int unsigned IrqStatusReg = 0;
  localparam int unsigned IrqMaskReg   = 1;
  localparam int unsigned IrqRawReg    = 2;

  // Read data returned by errored or timed-out accesses.
  localparam logic [63:0] ErrRdData = '0;

  // Byte-address bits [1:0] are ignored; the register field starts at bit 2.
  localparam int unsigned RegLsb = 2;

  function automatic int unsigned slot_lsb(input int unsigned reg_w);
    return RegLsb + reg_w;
  endfunction

  // One extra index is always reserved so the top index is never a real slot.
  function automatic int unsigned slot_w(input int unsigned num_slots);
    return $clog2(num_slots + 1);
  endfunction

endpackage

// File: rtl/io_irq_ctrl.sv
// Interrupt controller living at the reserved top slot index of io_slot_bridge.
// Registers: IRQ_STATUS (RO, slot_irq & mask), IRQ_MASK (RW), IRQ_RAW (RO).
// Other offsets read 0 and ignore writes.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   slot_irq_i         level interrupts from the slots
//   wr_en_i            one-cycle write strobe for the addressed register
//   reg_addr_i         register offset
//   wr_data_i          write data
//   rd_data_o          combinational read data for reg_addr_i
//   irq_o              registered OR of the unmasked interrupts
module io_irq_ctrl
  import io_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 16,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_SLOTS-1:0] slot_irq_i,
  input  logic                 wr_en_i,
  input  logic [REG_W-1:0]     reg_addr_i,
  input  logic [DATA_W-1:0]    wr_data_i,
  output logic [DATA_W-1:0]    rd_data_o,
  output logic                 irq_o
);

  logic [NUM_SLOTS-1:0] mask_q, mask_d;
  logic                 irq_q, irq_d;
  logic [NUM_SLOTS-1:0] status;

  // Only the low NUM_SLOTS bits of the write data reach the mask.
  logic unused_wdata;
  assign unused_wdata = ^wr_data_i;

  assign status = slot_irq_i & mask_q;

  always_comb begin
    mask_d = mask_q;
    if (wr_en_i && (reg_addr_i == REG_W'(IrqMaskReg))) begin
      mask_d = NUM_SLOTS'(wr_data_i);
    end
    irq_d = |status;
  end

  always_comb begin
    rd_data_o = '0;
    case (reg_addr_i)
      REG_W'(IrqStatusReg): rd_data_o = DATA_W'(status);
      REG_W'(IrqMaskReg):   rd_data_o = DATA_W'(mask_q);
      REG_W'(IrqRawReg):    rd_data_o = DATA_W'(slot_irq_i);
      default:              rd_data_o = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/io_slot_bridge.sv
// Handshaked MMIO bridge decoding CPU bus accesses into NUM_SLOTS peripheral slots.
// Each access strobes the addressed slot for one cycle, waits for its slot_ready (bounded
// by TIMEOUT_CYCLES, 0 = no timeout) and returns a one-cycle bus_ready with bus_err.
// Optional feature macro: IO_IRQ_EN maps the top slot index onto an interrupt controller
// and drives irq; without it irq is 0 and that index errors like any unmapped slot.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   bus_cs_i/bus_wr_i/bus_rd_i         request qualifiers (wr wins when both set)
//   bus_addr_i, bus_wr_data_i          byte address and write data
//   bus_rd_data_o, bus_ready_o, bus_err_o  completion (data held until next completion)
//   slot_cs_o/slot_rd_o/slot_wr_o      one-hot, one-cycle strobes
//   slot_reg_addr_o, slot_wr_data_o    latched address/data broadcast to all slots
//   slot_rd_data_i, slot_ready_i       per-slot response
//   slot_irq_i, irq_o                  slot interrupts and aggregated interrupt
module io_slot_bridge
  import io_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 16,
  parameter int unsigned REG_W          = 5,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          bus_cs_i,
  input  logic                          bus_wr_i,
  input  logic                          bus_rd_i,
  input  logic [31:0]                   bus_addr_i,
  input  logic [DATA_W-1:0]             bus_wr_data_i,
  output logic [DATA_W-1:0]             bus_rd_data_o,
  output logic                          bus_ready_o,
  output logic                          bus_err_o,
  output logic [NUM_SLOTS-1:0]          slot_cs_o,
  output logic [NUM_SLOTS-1:0]          slot_rd_o,
  output logic [NUM_SLOTS-1:0]          slot_wr_o,
  output logic [NUM_SLOTS*REG_W-1:0]    slot_reg_addr_o,
  output logic [NUM_SLOTS*DATA_W-1:0]   slot_wr_data_o,
  input  logic [NUM_SLOTS*DATA_W-1:0]   slot_rd_data_i,
  input  logic [NUM_SLOTS-1:0]          slot_ready_i,
  input  logic [NUM_SLOTS-1:0]          slot_irq_i,
  output logic                          irq_o
);

  localparam int unsigned SLOT_W  = slot_w(NUM_SLOTS);
  localparam int unsigned SlotLsb = slot_lsb(REG_W);
  localparam int unsigned SlotMsb = SlotLsb + SLOT_W - 1;
  localparam int unsigned CntW    = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT_CYCLES);

  io_state_e           state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [REG_W-1:0]    reg_q, reg_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [NUM_SLOTS-1:0] slot_oh;
  logic                 slot_hit;
  logic                 ready_sel;
  logic [DATA_W-1:0]    rd_sel;
  logic                 is_ctrl;
  logic [DATA_W-1:0]    ctrl_rdata;
  logic                 req;
  logic                 strobe;

  logic unused_addr;
  assign unused_addr = ^{bus_addr_i[31:SlotMsb+1], bus_addr_i[1:0]};

  assign req = bus_cs_i & (bus_rd_i | bus_wr_i);

  // Indices >= NUM_SLOTS decode to an all-zero vector, so they never strobe or
  // see a ready.
  always_comb begin
    slot_oh = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (slot_q == SLOT_W'(i)) slot_oh[i] = 1'b1;
    end
  end

  assign slot_hit  = |slot_oh;
  assign ready_sel = |(slot_ready_i & slot_oh);

  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      rd_sel = rd_sel | (slot_rd_data_i[i*DATA_W +: DATA_W] & {DATA_W{slot_oh[i]}});
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          slot_d  = bus_addr_i[SlotMsb:SlotLsb];
          reg_d   = bus_addr_i[SlotLsb-1:RegLsb];
          wdata_d = bus_wr_data_i;
          wr_d    = bus_wr_i;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        cnt_d = CntW'(1);
        if (is_ctrl) begin
          rdata_d = wr_q ? '0 : ctrl_rdata;
          state_d = StDone;
        end else if (!slot_hit) begin
          err_d   = 1'b1;
          rdata_d = DATA_W'(ErrRdData);
          state_d = StDone;
        end else if (ready_sel) begin
          rdata_d = wr_q ? '0 : rd_sel;
          state_d = StDone;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        // A ready arriving on the timeout cycle still completes cleanly.
        if (ready_sel) begin
          rdata_d = wr_q ? '0 : rd_sel;
          state_d = StDone;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (cnt_q == TimeoutCnt) begin
            err_d   = 1'b1;
            rdata_d = DATA_W'(ErrRdData);
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      slot_q  <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign strobe = (state_q == StAccess);

  assign slot_cs_o       = strobe ? slot_oh : '0;
  assign slot_rd_o       = (strobe && !wr_q) ? slot_oh : '0;
  assign slot_wr_o       = (strobe && wr_q) ? slot_oh : '0;
  assign slot_reg_addr_o = {NUM_SLOTS{reg_q}};
  assign slot_wr_data_o  = {NUM_SLOTS{wdata_q}};

  assign bus_ready_o   = (state_q == StDone);
  assign bus_err_o     = bus_ready_o & err_q;
  assign bus_rd_data_o = rdata_q;

`ifdef IO_IRQ_EN
  localparam logic [SLOT_W-1:0] CtrlSlot = '1;

  assign is_ctrl = (slot_q == CtrlSlot);

  io_irq_ctrl #(
    .NUM_SLOTS (NUM_SLOTS),
    .REG_W     (REG_W),
    .DATA_W    (DATA_W)
  ) u_irq_ctrl (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .slot_irq_i (slot_irq_i),
    .wr_en_i    (strobe && is_ctrl && wr_q),
    .reg_addr_i (reg_q),
    .wr_data_i  (wdata_q),
    .rd_data_o  (ctrl_rdata),
    .irq_o      (irq_o)
  );
`else
  logic unused_irq;
  assign unused_irq = ^slot_irq_i;
  assign is_ctrl    = 1'b0;
  assign ctrl_rdata = '0;
  assign irq_o      = 1'b0;
`endif

endmodule

// File: doc/io_slot_bridge.md
Name: io_slot_bridge

Overview:
- Parametrised, handshaked successor to the fixed 16-slot I/O controller.
- Decodes CPU bus accesses into NUM_SLOTS peripheral slots, each with its own ready handshake.
- Bounds every access with a timeout and reports bad or unanswered accesses on bus_err.
- Sits between the core's MMIO bus and peripheral slots (UART, SPI, matrix multiplier, CORDIC); optionally aggregates slot interrupts.

Parameters:
NUM_SLOTS, 16, number of peripheral slots; localparam SLOT_W = $clog2(NUM_SLOTS+1), so slot index 2^SLOT_W-1 is always spare.
REG_W, 5, register-address width per slot.
DATA_W, 32, data width.
TIMEOUT_CYCLES, 255, cycles to wait for slot_ready before erroring; 0 disables the timeout.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
bus_cs  in  1  bus chip select
bus_wr  in  1  write request
bus_rd  in  1  read request
bus_addr  in  32  byte address: [1:0] ignored, reg = [REG_W+1:2], slot = [REG_W+SLOT_W+1:REG_W+2]
bus_wr_data  in  DATA_W  write data
bus_rd_data  out  DATA_W  read data, valid while bus_ready=1
bus_ready  out  1  one-cycle access-complete pulse
bus_err  out  1  error qualifier, valid with bus_ready
slot_cs  out  NUM_SLOTS  one-hot slot select, one-cycle strobe
slot_rd  out  NUM_SLOTS  read strobe, one cycle
slot_wr  out  NUM_SLOTS  write strobe, one cycle
slot_reg_addr  out  NUM_SLOTS*REG_W  latched register address, broadcast to all slots
slot_wr_data  out  NUM_SLOTS*DATA_W  latched write data, broadcast to all slots
slot_rd_data  in  NUM_SLOTS*DATA_W  per-slot read data
slot_ready  in  NUM_SLOTS  per-slot completion; sampled only for the active slot
slot_irq  in  NUM_SLOTS  level interrupt per slot
irq  out  1  aggregated interrupt

Behaviour:
- Reset (async, low): FSM to IDLE. All outputs 0, including latched address/data, irq and IRQ_MASK.
- FSM states IDLE, ACCESS, WAIT, DONE.
- IDLE: if bus_cs & (bus_rd|bus_wr) at edge T:
  - latch slot, reg, wr_data and direction;
  - bus_wr=bus_rd=1 is treated as a write, no error;
  - go to ACCESS.
- ACCESS (T+1):
  - assert slot_cs[s] plus slot_rd[s] or slot_wr[s] for exactly one cycle;
  - if slot_ready[s]=1 in this cycle, capture slot_rd_data[s] and go to DONE; otherwise go to WAIT.
- WAIT:
  - strobes low; slot_reg_addr and slot_wr_data stay held;
  - the cycle counter, started in ACCESS, increments each cycle;
  - slot_ready[s] -> capture data, go to DONE;
  - counter reaches TIMEOUT_CYCLES -> bus_rd_data=0, set the error flag, go to DONE.
- DONE: bus_ready=1 for exactly one cycle, with bus_err as flagged; then go to IDLE.
  - Minimum latency is request at T, bus_ready at T+2.
- Slot index >= NUM_SLOTS (except the controller index when IO_IRQ_EN is defined): no strobes, DONE at T+2, bus_err=1, rd_data=0.
- The master holds its request stable until bus_ready and drops it on the following edge. Requests outside IDLE are ignored and not queued.
- bus_rd_data holds its value after DONE until the next capture. Writes return 0.
- slot_ready[s] arriving on the same cycle the timeout count is reached: ready wins, no error.
- slot_ready from non-active slots is ignored.
- Reset mid-access: strobes drop immediately; no bus_ready is issued.

Optional Feature:
- Macro IO_IRQ_EN.
- Defined:
  - slot index 2^SLOT_W-1 maps to internal registers: reg0 IRQ_STATUS (RO, slot_irq & mask), reg1 IRQ_MASK (RW, reset 0), reg2 IRQ_RAW (RO, slot_irq);
  - other regs read 0 and ignore writes, no error;
  - internal accesses complete at T+2, no strobes;
  - irq registered: irq = |(slot_irq & IRQ_MASK), one-cycle latency.
- Not defined: irq tied 0, slot_irq unused, the controller index behaves as an unmapped slot (error).

Decomposition:
- Package io_pkg holds: the state enum, IRQ register offsets (IRQ_STATUS=0, IRQ_MASK=1, IRQ_RAW=2), the error read-data constant 0, and the slot index/field-position helper localparams.
- One sub-module, io_irq_ctrl (mask register, status mux, irq flop), instantiated only under IO_IRQ_EN.

Test Plan:
- Example field positions assume NUM_SLOTS=16, SLOT_W=5, REG_W=5, so the slot field is [11:7].
- Read slot 2 reg 3 (addr 0x10C), slot_ready[2]=1 in ACCESS with data 0xCAFE0001 -> slot_rd[2] pulses at T+1; bus_ready at T+2 with 0xCAFE0001, bus_err=0.
- Write 0x55 to slot 0 reg 1 (addr 0x004), slot_ready delayed 5 cycles -> slot_wr[0] is one cycle only; addr/data held; bus_ready at T+7.
- Read slot 5 (addr 0x280), slot_ready never asserted, TIMEOUT_CYCLES=8 -> bus_ready with bus_err=1 and rd_data=0 after 8 cycles; FSM back in IDLE.
- Read slot 20 (addr 0xA00) -> no strobe; bus_ready at T+2 with bus_err=1.
- IO_IRQ_EN: write 0x0004 to 0xF84, raise slot_irq[2] -> irq=1 one cycle later; read 0xF80 returns 0x0004; raising slot_irq[3] alone leaves irq=0.
- Assert reset during WAIT -> strobes and bus_ready=0; next read completes normally.
